cache_mem_arbiter: RTL and testbench

- Shares the single physical-memory port between the instruction cache (line fills) and the data cache (line fills and write-backs).
- The data cache's fill path feeds read_data into the writeback stage.
- Grants one transaction at a time, registers the granted command, holds it on pmem until pmem_resp, then routes the response back to the owner.
- Breaks ties between simultaneous requesters with a one-bit round-robin pointer.

---
 rtl/cache_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single physical-memory port between icache fills and dcache fills/write-backs.
// One transaction at a time. Ties are broken by a one-bit round-robin pointer.
module cache_mem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  state_t                state;
  state_t                next_state;
  owner_t                last_grant;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic grant_i;
  logic grant_d;
  logic d_req;

  assign d_req = d_read | d_write;

  // State register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= OWNER_I;
    end else begin
      state <= next_state;
      if (grant_i) begin
        last_grant <= OWNER_I;
      end else if (grant_d) begin
        last_grant <= OWNER_D;
      end
    end
  end

  // Command latch; captured only at grant so requester changes while serving are ignored.
  // A read+write request from the dcache is treated as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else if (grant_i) begin
      addr_q <= i_address;
      op_q   <= OP_READ;
    end else if (grant_d) begin
      addr_q  <= d_address;
      wdata_q <= d_wdata;
      op_q    <= d_write ? OP_WRITE : OP_READ;
    end
  end

  // Next-state, grant decision and outputs
  always_comb begin
    next_state   = state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;

    unique case (state)
      IDLE: begin
        if (i_read && d_req) begin
          if (last_grant == OWNER_I) begin
            grant_d = 1'b1;
          end else begin
            grant_i = 1'b1;
          end
        end else if (i_read) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end

        if (grant_i) begin
          next_state = SERVE_I;
        end else if (grant_d) begin
          next_state = SERVE_D;
        end
      end

      SERVE_I: begin
        pmem_read  = (op_q == OP_READ);
        pmem_write = (op_q == OP_WRITE);
        if (pmem_resp) begin
          i_resp     = 1'b1;
          i_rdata    = pmem_rdata;
          next_state = IDLE;
        end
      end

      SERVE_D: begin
        pmem_read  = (op_q == OP_READ);
        pmem_write = (op_q == OP_WRITE);
        if (pmem_resp) begin
          d_resp     = 1'b1;
          d_rdata    = pmem_rdata;
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: lone fills, write-back, tie alternation,
// inputs changing mid-transaction, asynchronous reset mid-transaction, illegal read+write.
module tb_cache_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  localparam logic [LW-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] PAT_12 = {16{16'h1234}};
  localparam logic [LW-1:0] PAT_5A = {32{8'h5A}};
  localparam logic [LW-1:0] PAT_C3 = {32{8'hC3}};
  localparam logic [LW-1:0] PAT_0F = {32{8'h0F}};

  logic          clk;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_cmp = 0;
  int n_err = 0;

  cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    chk("rst_pmem_read",  LW'(pmem_read),    '0);
    chk("rst_pmem_write", LW'(pmem_write),   '0);
    chk("rst_pmem_addr",  LW'(pmem_address), '0);
    chk("rst_pmem_wdata", pmem_wdata,        '0);
    chk("rst_i_resp",     LW'(i_resp),       '0);
    chk("rst_d_resp",     LW'(d_resp),       '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Lone icache read
    i_read    = 1'b1;
    i_address = 32'h0000_0040;
    settle();
    chk("i_idle_no_cmd", LW'(pmem_read), '0);
    tick();
    chk("i_pmem_read",   LW'(pmem_read),    1);
    chk("i_pmem_write",  LW'(pmem_write),   '0);
    chk("i_pmem_addr",   LW'(pmem_address), LW'(32'h40));
    chk("i_no_early",    LW'(i_resp),       '0);
    tick();
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_A5;
    settle();
    chk("i_resp",        LW'(i_resp), 1);
    chk("i_rdata",       i_rdata,     PAT_A5);
    chk("i_d_resp_0",    LW'(d_resp), '0);
    chk("i_d_rdata_0",   d_rdata,     '0);
    tick();
    clear_inputs();
    settle();
    chk("i_resp_one",    LW'(i_resp),    '0);
    chk("i_back_idle",   LW'(pmem_read), '0);
    tick();

    // Dcache write-back
    d_write   = 1'b1;
    d_address = 32'h8000_0100;
    d_wdata   = PAT_12;
    tick();
    chk("dw_pmem_write", LW'(pmem_write),   1);
    chk("dw_pmem_read",  LW'(pmem_read),    '0);
    chk("dw_pmem_addr",  LW'(pmem_address), LW'(32'h8000_0100));
    chk("dw_pmem_wdata", pmem_wdata,        PAT_12);
    tick();
    chk("dw_hold_write", LW'(pmem_write),   1);
    chk("dw_hold_wdata", pmem_wdata,        PAT_12);
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_5A;
    settle();
    chk("dw_d_resp",     LW'(d_resp), 1);
    chk("dw_i_resp_0",   LW'(i_resp), '0);
    tick();
    clear_inputs();
    settle();
    chk("dw_resp_one",   LW'(d_resp),     '0);
    chk("dw_back_idle",  LW'(pmem_write), '0);

    // Ties straight after reset: D, I, D
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    i_read    = 1'b1;
    i_address = 32'h0000_1000;
    d_read    = 1'b1;
    d_address = 32'h0000_2000;
    tick();
    chk("tie1_addr_d",   LW'(pmem_address), LW'(32'h2000));
    chk("tie1_read",     LW'(pmem_read),    1);
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_C3;
    settle();
    chk("tie1_d_resp",   LW'(d_resp), 1);
    chk("tie1_d_rdata",  d_rdata,     PAT_C3);
    chk("tie1_i_resp_0", LW'(i_resp), '0);
    tick();
    pmem_resp = 1'b0;
    settle();
    chk("tie_gap1_idle", LW'(pmem_read), '0);
    tick();
    chk("tie2_addr_i",   LW'(pmem_address), LW'(32'h1000));
    chk("tie2_read",     LW'(pmem_read),    1);
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_0F;
    settle();
    chk("tie2_i_resp",   LW'(i_resp), 1);
    chk("tie2_i_rdata",  i_rdata,     PAT_0F);
    chk("tie2_d_resp_0", LW'(d_resp), '0);
    tick();
    pmem_resp = 1'b0;
    settle();
    chk("tie_gap2_idle", LW'(pmem_read), '0);
    tick();
    chk("tie3_addr_d",   LW'(pmem_address), LW'(32'h2000));
    pmem_resp = 1'b1;
    settle();
    chk("tie3_d_resp",   LW'(d_resp), 1);
    tick();
    clear_inputs();
    tick();

    // Requester inputs change while serving dcache
    d_read    = 1'b1;
    d_address = 32'h0000_0200;
    tick();
    chk("mid_addr0",     LW'(pmem_address), LW'(32'h200));
    d_address = 32'h0000_0300;
    i_read    = 1'b1;
    i_address = 32'h0000_0400;
    settle();
    chk("mid_addr1",     LW'(pmem_address), LW'(32'h200));
    tick();
    chk("mid_addr2",     LW'(pmem_address), LW'(32'h200));
    chk("mid_still_rd",  LW'(pmem_read),    1);
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_A5;
    settle();
    chk("mid_d_resp",    LW'(d_resp), 1);
    chk("mid_i_resp_0",  LW'(i_resp), '0);
    tick();
    d_read    = 1'b0;
    pmem_resp = 1'b0;
    settle();
    chk("mid_gap_idle",  LW'(pmem_read), '0);
    tick();
    chk("mid_i_granted", LW'(pmem_address), LW'(32'h400));
    pmem_resp = 1'b1;
    settle();
    chk("mid_i_resp",    LW'(i_resp), 1);
    tick();
    clear_inputs();
    tick();

    // Asynchronous reset while serving icache
    i_read    = 1'b1;
    i_address = 32'h0000_0500;
    tick();
    chk("rmid_read",     LW'(pmem_read), 1);
    rst_n     = 1'b0;
    i_read    = 1'b0;
    pmem_resp = 1'b1;
    settle();
    chk("rmid_drop",     LW'(pmem_read), '0);
    chk("rmid_no_iresp", LW'(i_resp),    '0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rmid_idle_ir",  LW'(i_resp),    '0);
    chk("rmid_idle_dr",  LW'(d_resp),    '0);
    chk("rmid_idle_rd",  LW'(pmem_read), '0);
    tick();
    clear_inputs();
    tick();

    // Illegal read+write request is treated as a write
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_0600;
    d_wdata   = PAT_C3;
    tick();
    chk("ill_write",     LW'(pmem_write), 1);
    chk("ill_read",      LW'(pmem_read),  '0);
    chk("ill_wdata",     pmem_wdata,      PAT_C3);
    tick();
    pmem_resp = 1'b1;
    settle();
    chk("ill_write_end", LW'(pmem_write), 1);
    chk("ill_read_end",  LW'(pmem_read),  '0);
    chk("ill_d_resp",    LW'(d_resp),     1);
    tick();
    clear_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
